// File: rtl/h2e_pkt_screen.sv
// Store-and-forward screening buffer for the h2e path. A packet is released downstream
// only when it completes with legal tkeep, at least MIN_BYTES and at most 2^BYTE_MTU bytes.
module h2e_pkt_screen #(
    parameter int BYTE_MTU  = 10,
    parameter int MIN_BYTES = 14,
    parameter int CNT_W     = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             clear,
    input  logic [63:0]      s_axis_tdata,
    input  logic [7:0]       s_axis_tkeep,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [63:0]      m_axis_tdata,
    output logic [7:0]       m_axis_tkeep,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] drop_count,
    output logic [1:0]       drop_reason
);
    localparam int AW    = BYTE_MTU - 2;
    localparam int PW    = AW + 1;
    localparam int D     = 1 << AW;
    localparam int MAX_W = 1 << (BYTE_MTU - 3);
    localparam int LW    = BYTE_MTU + 1;
    localparam int WW    = 73;

    typedef enum logic {ST_ACCEPT, ST_DISCARD} wr_state_e;

    wr_state_e        state_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_commit_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [AW-1:0]    beats_q;
    logic [LW-1:0]    byte_len_q;
    logic             bad_keep_q;
    logic             rdy_en_q;
    logic [CNT_W-1:0] pkt_count_q;
    logic [CNT_W-1:0] drop_count_q;
    logic [1:0]       drop_reason_q;

    logic [WW-1:0]    mem [D];
    logic [WW-1:0]    rd_word_q;
    logic             rd_vld_q;
    logic             m_vld_q;
    logic [WW-1:0]    m_word_q;

    logic             s_fire;
    logic [3:0]       keep_pop;
    logic [7:0]       keep_p1;
    logic             keep_last_ok;
    logic             beat_bad;
    logic             pkt_bad;
    logic             oversize;
    logic             wr_en;
    logic [LW-1:0]    len_next;
    logic [PW-1:0]    used;
    logic             out_ready;
    logic             fetch;

    always_comb begin
        keep_pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            keep_pop = keep_pop + {3'd0, s_axis_tkeep[i]};
        end
    end

    // A legal last-beat tkeep is a non-empty run of ones starting at bit 0.
    assign keep_p1      = s_axis_tkeep + 8'd1;
    assign keep_last_ok = (s_axis_tkeep != 8'h00) && ((s_axis_tkeep & keep_p1) == 8'h00);
    assign beat_bad     = s_axis_tlast ? !keep_last_ok : (s_axis_tkeep != 8'hFF);
    assign pkt_bad      = bad_keep_q || beat_bad;
    assign len_next     = byte_len_q + LW'(keep_pop);
    assign oversize     = (state_q == ST_ACCEPT) && (beats_q == AW'(MAX_W));
    assign used         = wr_ptr_q - rd_ptr_q;

    assign s_axis_tready = rdy_en_q && ((state_q == ST_DISCARD) || (used != PW'(D)));
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign wr_en         = s_fire && (state_q == ST_ACCEPT) && !oversize;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= ST_ACCEPT;
            wr_ptr_q      <= '0;
            wr_commit_q   <= '0;
            beats_q       <= '0;
            byte_len_q    <= '0;
            bad_keep_q    <= 1'b0;
            rdy_en_q      <= 1'b0;
            pkt_count_q   <= '0;
            drop_count_q  <= '0;
            drop_reason_q <= 2'd0;
        end else begin
            rdy_en_q <= 1'b1;
            if (s_fire) begin
                case (state_q)
                    ST_ACCEPT: begin
                        if (oversize) begin
                            wr_ptr_q      <= wr_commit_q;
                            drop_count_q  <= drop_count_q + 1'b1;
                            drop_reason_q <= 2'd1;
                            beats_q       <= '0;
                            byte_len_q    <= '0;
                            bad_keep_q    <= 1'b0;
                            if (!s_axis_tlast) begin
                                state_q <= ST_DISCARD;
                            end
                        end else if (s_axis_tlast) begin
                            beats_q    <= '0;
                            byte_len_q <= '0;
                            bad_keep_q <= 1'b0;
                            if (pkt_bad) begin
                                wr_ptr_q      <= wr_commit_q;
                                drop_count_q  <= drop_count_q + 1'b1;
                                drop_reason_q <= 2'd2;
                            end else if (len_next < LW'(MIN_BYTES)) begin
                                wr_ptr_q      <= wr_commit_q;
                                drop_count_q  <= drop_count_q + 1'b1;
                                drop_reason_q <= 2'd3;
                            end else begin
                                wr_ptr_q    <= wr_ptr_q + 1'b1;
                                wr_commit_q <= wr_ptr_q + 1'b1;
                                pkt_count_q <= pkt_count_q + 1'b1;
                            end
                        end else begin
                            wr_ptr_q   <= wr_ptr_q + 1'b1;
                            beats_q    <= beats_q + 1'b1;
                            byte_len_q <= len_next;
                            bad_keep_q <= pkt_bad;
                        end
                    end
                    ST_DISCARD: begin
                        if (s_axis_tlast) begin
                            state_q <= ST_ACCEPT;
                        end
                    end
                    default: state_q <= ST_ACCEPT;
                endcase
            end
            if (clear) begin
                pkt_count_q   <= '0;
                drop_count_q  <= '0;
                drop_reason_q <= 2'd0;
            end
        end
    end

    // Read pipeline: registered RAM output feeding a one-entry output register.
    assign out_ready = !m_vld_q || m_axis_tready;
    assign fetch     = (rd_ptr_q != wr_commit_q) && (!rd_vld_q || out_ready);

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
        if (fetch) begin
            rd_word_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_ptr_q <= '0;
            rd_vld_q <= 1'b0;
            m_vld_q  <= 1'b0;
            m_word_q <= '0;
        end else begin
            if (fetch) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            rd_vld_q <= fetch || (rd_vld_q && !out_ready);
            if (out_ready) begin
                m_vld_q <= rd_vld_q;
                if (rd_vld_q) begin
                    m_word_q <= rd_word_q;
                end
            end
        end
    end

    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = m_word_q;
    assign m_axis_tvalid = m_vld_q;
    assign pkt_count     = pkt_count_q;
    assign drop_count    = drop_count_q;
    assign drop_reason   = drop_reason_q;
endmodule
